// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA drawing stages.
//   X_W/Y_W    : pixel coordinate widths from the 640x480 timing generator
//   C_W        : bits per colour channel on the board pins
//   SQx_*      : open-interval bounds of the four fixed squares
//   fsm_e      : highlight-rotation state (RUN / PAUSED)
//   stage1_t   : first pipeline stage contents (syncs, active, hit vector)
package vga_pkg;

  localparam int X_W    = 10;
  localparam int Y_W    = 9;
  localparam int C_W    = 4;
  localparam int RGB_W  = 3 * C_W;
  localparam int NSQ    = 4;
  localparam int FCNT_W = 8;
  localparam int SEL_W  = 2;

  // Bounds are exclusive: a pixel hits when lo < coord < hi on both axes.
  localparam logic [X_W-1:0] SQ0_X_LO = 10'd0;
  localparam logic [X_W-1:0] SQ0_X_HI = 10'd150;
  localparam logic [Y_W-1:0] SQ0_Y_LO = 9'd0;
  localparam logic [Y_W-1:0] SQ0_Y_HI = 9'd110;
  localparam logic [X_W-1:0] SQ1_X_LO = 10'd155;
  localparam logic [X_W-1:0] SQ1_X_HI = 10'd305;
  localparam logic [Y_W-1:0] SQ1_Y_LO = 9'd115;
  localparam logic [Y_W-1:0] SQ1_Y_HI = 9'd225;
  localparam logic [X_W-1:0] SQ2_X_LO = 10'd310;
  localparam logic [X_W-1:0] SQ2_X_HI = 10'd460;
  localparam logic [Y_W-1:0] SQ2_Y_LO = 9'd230;
  localparam logic [Y_W-1:0] SQ2_Y_HI = 9'd335;
  localparam logic [X_W-1:0] SQ3_X_LO = 10'd465;
  localparam logic [X_W-1:0] SQ3_X_HI = 10'd615;
  localparam logic [Y_W-1:0] SQ3_Y_LO = 9'd340;
  localparam logic [Y_W-1:0] SQ3_Y_HI = 9'd450;

  typedef struct packed {
    logic [X_W-1:0] x_lo;
    logic [X_W-1:0] x_hi;
    logic [Y_W-1:0] y_lo;
    logic [Y_W-1:0] y_hi;
  } sq_box_t;

  function automatic sq_box_t sq_box(input int idx);
    case (idx)
      0:       return '{SQ0_X_LO, SQ0_X_HI, SQ0_Y_LO, SQ0_Y_HI};
      1:       return '{SQ1_X_LO, SQ1_X_HI, SQ1_Y_LO, SQ1_Y_HI};
      2:       return '{SQ2_X_LO, SQ2_X_HI, SQ2_Y_LO, SQ2_Y_HI};
      default: return '{SQ3_X_LO, SQ3_X_HI, SQ3_Y_LO, SQ3_Y_HI};
    endcase
  endfunction

  typedef enum logic {
    RUN    = 1'b0,
    PAUSED = 1'b1
  } fsm_e;

  typedef struct packed {
    logic           active;
    logic           hs;
    logic           vs;
    logic [NSQ-1:0] hit;
  } stage1_t;

  // Syncs are active-low, so their idle (reset) level is 1.
  localparam stage1_t S1_RST = '{active: 1'b0, hs: 1'b1, vs: 1'b1, hit: '0};

endpackage

// File: rtl/vga_square_decode.sv
// Combinational square hit decoder.
//   x, y : pixel coordinate
//   hit  : one-hot (or zero) vector, bit i set when the pixel lies strictly
//          inside square i
module vga_square_decode
  import vga_pkg::*;
(
  input  logic [X_W-1:0] x,
  input  logic [Y_W-1:0] y,
  output logic [NSQ-1:0] hit
);

  sq_box_t box;

  always_comb begin
    hit = '0;
    box = '0;
    for (int i = 0; i < NSQ; i++) begin
      box    = sq_box(i);
      hit[i] = (x > box.x_lo) && (x < box.x_hi) &&
               (y > box.y_lo) && (y < box.y_hi);
    end
  end

endmodule

// File: rtl/vga_square_painter.sv
// Pixel colouring stage behind the 640x480 VGA timing generator.
// Paints four fixed squares, one highlighted; the highlight rotates every
// HOLD_FRAMES frames (legal 1..255) unless paused. Two-stage pipeline on
// i_pix_stb; syncs travel with colour so they stay pixel-aligned.
//   i_clk, i_rst         : clock, synchronous active-high reset
//   i_pix_stb            : pixel enable, everything advances only on it
//   i_x, i_y, i_active   : pixel position and visible-area flag
//   i_hs, i_vs           : active-low syncs from the generator
//   i_frame_end          : last-pixel-of-frame marker
//   i_pause              : freeze rotation (sampled at frame end)
//   o_hs, o_vs, o_r/g/b  : pin outputs, 2 strobes after inputs
//   o_sel                : highlighted square index
module vga_square_painter
  import vga_pkg::*;
#(
  parameter int               HOLD_FRAMES = 60,
  parameter logic [RGB_W-1:0] HI_RGB      = 12'hFFF,
  parameter logic [RGB_W-1:0] SQ_RGB      = 12'hF00,
  parameter logic [RGB_W-1:0] BG_RGB      = 12'h000
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_pix_stb,
  input  logic [X_W-1:0]   i_x,
  input  logic [Y_W-1:0]   i_y,
  input  logic             i_active,
  input  logic             i_hs,
  input  logic             i_vs,
  input  logic             i_frame_end,
  input  logic             i_pause,
  output logic             o_hs,
  output logic             o_vs,
  output logic [C_W-1:0]   o_r,
  output logic [C_W-1:0]   o_g,
  output logic [C_W-1:0]   o_b,
  output logic [SEL_W-1:0] o_sel
);

  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(HOLD_FRAMES - 1);

  // ---------------- highlight rotation ----------------
  fsm_e              state, state_nxt;
  logic [FCNT_W-1:0] fcnt;
  logic [SEL_W-1:0]  sel;
  logic              fe_evt;
  logic              cnt_en;

  assign fe_evt = i_pix_stb && i_frame_end;

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= RUN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (fe_evt) state_nxt = i_pause ? PAUSED : RUN;
  end

  // Leaving PAUSED consumes that frame end without counting.
  always_comb begin
    cnt_en = fe_evt && !i_pause && (state == RUN);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fcnt <= '0;
      sel  <= '0;
    end else if (cnt_en) begin
      if (fcnt == FCNT_LAST) begin
        fcnt <= '0;
        sel  <= sel + 1'b1;
      end else begin
        fcnt <= fcnt + 1'b1;
      end
    end
  end

  assign o_sel = sel;

  // ---------------- stage 1 ----------------
  logic [NSQ-1:0]     hit;
  stage1_t            s1;
  // Registered position kept for later drawing stages tapping this pipeline.
  logic [X_W+Y_W-1:0] s1_pos_unused;

  vga_square_decode u_decode (
    .x   (i_x),
    .y   (i_y),
    .hit (hit)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1            <= S1_RST;
      s1_pos_unused <= '0;
    end else if (i_pix_stb) begin
      s1            <= '{active: i_active, hs: i_hs, vs: i_vs, hit: hit};
      s1_pos_unused <= {i_x, i_y};
    end
  end

  // ---------------- stage 2 ----------------
  logic [RGB_W-1:0] rgb_nxt;

  // sel only moves at frame end, which falls in blanking, so the visible
  // area of a frame sees a single highlight position.
  always_comb begin
    rgb_nxt = BG_RGB;
    if (!s1.active)     rgb_nxt = '0;
    else if (s1.hit[sel]) rgb_nxt = HI_RGB;
    else if (|s1.hit)   rgb_nxt = SQ_RGB;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      {o_r, o_g, o_b} <= '0;
      o_hs            <= 1'b1;
      o_vs            <= 1'b1;
    end else if (i_pix_stb) begin
      {o_r, o_g, o_b} <= rgb_nxt;
      o_hs            <= s1.hs;
      o_vs            <= s1.vs;
    end
  end

endmodule

// File: tb/tb_vga_square_painter.sv
// Two painters share one stimulus stream: A uses default colours with
// HOLD_FRAMES=2, B uses distinct colours with HOLD_FRAMES=1. A behavioural
// model predicts both every cycle; directed steps pin it with literals.
module tb_vga_square_painter;

  localparam int          H_A  = 2;
  localparam int          H_B  = 1;
  localparam logic [11:0] HI_B = 12'h1E7;
  localparam logic [11:0] SQ_B = 12'h936;
  localparam logic [11:0] BG_B = 12'h24C;

  logic       i_clk = 1'b0, i_rst = 1'b0, i_pix_stb = 1'b0, i_active = 1'b0;
  logic       i_hs = 1'b1, i_vs = 1'b1, i_frame_end = 1'b0, i_pause = 1'b0;
  logic [9:0] i_x = '0;
  logic [8:0] i_y = '0;

  logic       hs_a, vs_a, hs_b, vs_b;
  logic [3:0] r_a, g_a, b_a, r_b, g_b, b_b;
  logic [1:0] sel_a, sel_b;
  logic [11:0] rgb_a, rgb_b;
  assign rgb_a = {r_a, g_a, b_a};
  assign rgb_b = {r_b, g_b, b_b};

  vga_square_painter #(.HOLD_FRAMES(H_A)) dut_a (
    .i_clk(i_clk), .i_rst(i_rst), .i_pix_stb(i_pix_stb), .i_x(i_x), .i_y(i_y),
    .i_active(i_active), .i_hs(i_hs), .i_vs(i_vs), .i_frame_end(i_frame_end),
    .i_pause(i_pause), .o_hs(hs_a), .o_vs(vs_a), .o_r(r_a), .o_g(g_a),
    .o_b(b_a), .o_sel(sel_a));

  vga_square_painter #(.HOLD_FRAMES(H_B), .HI_RGB(HI_B), .SQ_RGB(SQ_B),
                       .BG_RGB(BG_B)) dut_b (
    .i_clk(i_clk), .i_rst(i_rst), .i_pix_stb(i_pix_stb), .i_x(i_x), .i_y(i_y),
    .i_active(i_active), .i_hs(i_hs), .i_vs(i_vs), .i_frame_end(i_frame_end),
    .i_pause(i_pause), .o_hs(hs_b), .o_vs(vs_b), .o_r(r_b), .o_g(g_b),
    .o_b(b_b), .o_sel(sel_b));

  always #5 i_clk = ~i_clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int x; int y; bit act; bit hs; bit vs; } pix_t;

  function automatic int sq_of(input int x, input int y);
    if (x > 0   && x < 150 && y > 0   && y < 110) return 0;
    if (x > 155 && x < 305 && y > 115 && y < 225) return 1;
    if (x > 310 && x < 460 && y > 230 && y < 335) return 2;
    if (x > 465 && x < 615 && y > 340 && y < 450) return 3;
    return -1;
  endfunction

  function automatic logic [11:0] colour(input pix_t p, input int sel, input int d);
    int h;
    h = sq_of(p.x, p.y);
    if (!p.act) return 12'h000;
    if (h == sel) return (d == 0) ? 12'hFFF : HI_B;
    if (h >= 0)   return (d == 0) ? 12'hF00 : SQ_B;
    return (d == 0) ? 12'h000 : BG_B;
  endfunction

  pix_t        pend;          // last accepted pixel, shown on the next strobe
  int          m_sel[2], m_fcnt[2];
  bit          m_paused[2];
  logic [11:0] e_rgb[2];
  bit          e_hs, e_vs;
  bit          model_ok = 1'b0;

  always @(posedge i_clk) begin
    if (i_rst) begin
      model_ok = 1'b1;
      for (int d = 0; d < 2; d++) begin
        m_sel[d] = 0; m_fcnt[d] = 0; m_paused[d] = 1'b0; e_rgb[d] = 12'h000;
      end
      e_hs = 1'b1; e_vs = 1'b1;
      pend.x = 0; pend.y = 0; pend.act = 1'b0; pend.hs = 1'b1; pend.vs = 1'b1;
    end else if (i_pix_stb) begin
      for (int d = 0; d < 2; d++) e_rgb[d] = colour(pend, m_sel[d], d);
      e_hs = pend.hs; e_vs = pend.vs;
      pend.x = int'(i_x); pend.y = int'(i_y);
      pend.act = i_active; pend.hs = i_hs; pend.vs = i_vs;
      if (i_frame_end) begin
        for (int d = 0; d < 2; d++) begin
          if (i_pause) m_paused[d] = 1'b1;
          else if (m_paused[d]) m_paused[d] = 1'b0;
          else begin
            m_fcnt[d]++;
            if (m_fcnt[d] == ((d == 0) ? H_A : H_B)) begin
              m_fcnt[d] = 0;
              m_sel[d]  = (m_sel[d] + 1) % 4;
            end
          end
        end
      end
    end
  end

  always @(negedge i_clk) begin
    if (model_ok) begin
      chk("rgb_a", rgb_a, e_rgb[0]);
      chk("rgb_b", rgb_b, e_rgb[1]);
      chk("hs_a", hs_a, e_hs);
      chk("vs_a", vs_a, e_vs);
      chk("hs_b", hs_b, e_hs);
      chk("vs_b", vs_b, e_vs);
      chk("sel_a", sel_a, m_sel[0]);
      chk("sel_b", sel_b, m_sel[1]);
    end
  end

  // ---------------- stimulus ----------------
  // One pixel strobe then three idle clocks (25 MHz out of 100 MHz).
  task automatic pix(input int x, input int y, input bit act, input bit hs,
                     input bit vs, input bit fe, input bit pz);
    i_x = 10'(x); i_y = 9'(y); i_active = act; i_hs = hs; i_vs = vs;
    i_frame_end = fe; i_pause = pz; i_pix_stb = 1'b1;
    @(negedge i_clk);
    i_pix_stb = 1'b0; i_frame_end = 1'b0;
    repeat (3) @(negedge i_clk);
  endtask

  task automatic frame_end(input bit pz);
    pix(700, 500, 1'b0, 1'b1, 1'b1, 1'b1, pz);
  endtask

  function automatic int near(input int b);
    int v;
    v = b + $urandom_range(0, 2) - 1;
    return (v < 0) ? 0 : v;
  endfunction

  function automatic int rnd_x();
    int b;
    case ($urandom_range(0, 7))
      0: b = 0;   1: b = 150; 2: b = 155; 3: b = 305;
      4: b = 310; 5: b = 460; 6: b = 465; default: b = 615;
    endcase
    return ($urandom_range(0, 1) == 1) ? near(b) : $urandom_range(0, 799);
  endfunction

  function automatic int rnd_y();
    int b;
    case ($urandom_range(0, 7))
      0: b = 0;   1: b = 110; 2: b = 115; 3: b = 225;
      4: b = 230; 5: b = 335; 6: b = 340; default: b = 450;
    endcase
    return ($urandom_range(0, 1) == 1) ? near(b) : $urandom_range(0, 511);
  endfunction

  initial begin
    @(negedge i_clk);
    // reset state
    i_rst = 1'b1;
    repeat (3) @(negedge i_clk);
    chk("rst_rgb", rgb_a, 12'h000);
    chk("rst_hs", hs_a, 1);
    chk("rst_vs", vs_a, 1);
    chk("rst_sel", sel_a, 0);
    i_rst = 1'b0;
    @(negedge i_clk);

    // latency and colour selection
    pix(10, 10, 1, 0, 1, 0, 0);
    pix(10, 10, 1, 1, 0, 0, 0);
    chk("hi_a", rgb_a, 12'hFFF);
    chk("hi_b", rgb_b, HI_B);
    chk("hs_delay", hs_a, 0);
    chk("vs_delay", vs_a, 1);
    pix(160, 120, 1, 1, 1, 0, 0);
    chk("hs_delay2", hs_a, 1);
    chk("vs_delay2", vs_a, 0);
    pix(150, 50, 1, 1, 1, 0, 0);
    chk("sq1_a", rgb_a, 12'hF00);
    chk("sq1_b", rgb_b, SQ_B);
    pix(700, 50, 0, 1, 1, 0, 0);
    chk("edge_a", rgb_a, 12'h000);
    chk("edge_b", rgb_b, BG_B);
    pix(700, 50, 0, 1, 1, 0, 0);
    chk("blank_b", rgb_b, 12'h000);

    // rotation
    for (int k = 0; k < 8; k++) begin
      frame_end(0);
      chk("rot_a", sel_a, ((k + 1) / 2) % 4);
      chk("rot_b", sel_b, (k + 1) % 4);
    end

    // pause
    frame_end(0);                          // A fcnt=1 sel=0, B sel=1
    for (int k = 0; k < 3; k++) begin
      frame_end(1);
      chk("pause_a", sel_a, 0);
      chk("pause_b", sel_b, 1);
    end
    frame_end(0);
    chk("unpause_a", sel_a, 0);
    chk("unpause_b", sel_b, 1);
    frame_end(0);
    chk("resume_a", sel_a, 1);
    chk("resume_b", sel_b, 2);

    // mid-frame reset with sel=2, frame end during reset ignored
    frame_end(0);
    frame_end(0);
    chk("pre_rst_sel", sel_a, 2);
    pix(10, 10, 1, 0, 0, 0, 0);
    pix(10, 10, 1, 0, 0, 0, 0);
    chk("pre_rst_rgb", rgb_a, 12'hF00);
    chk("pre_rst_hs", hs_a, 0);
    i_rst = 1'b1; i_frame_end = 1'b1; i_pix_stb = 1'b0;
    @(negedge i_clk);
    chk("mrst_rgb", rgb_a, 12'h000);
    chk("mrst_hs", hs_a, 1);
    chk("mrst_vs", vs_a, 1);
    chk("mrst_sel", sel_a, 0);
    i_pix_stb = 1'b1;
    @(negedge i_clk);
    i_pix_stb = 1'b0; i_frame_end = 1'b0; i_rst = 1'b0;
    repeat (3) @(negedge i_clk);
    chk("rst_fe_sel", sel_a, 0);
    frame_end(0);
    chk("post_rst_a", sel_a, 0);
    chk("post_rst_b", sel_b, 1);
    frame_end(0);
    chk("post_rst_a2", sel_a, 1);
    pix(10, 10, 1, 0, 0, 0, 0);
    pix(10, 10, 1, 1, 1, 0, 0);
    chk("resume_rgb", rgb_a, 12'hF00);
    chk("resume_hs", hs_a, 0);

    // strobe held low: nothing moves
    pix(160, 120, 1, 1, 1, 0, 0);
    pix(160, 120, 1, 1, 1, 0, 0);
    for (int i = 0; i < 10; i++) begin
      i_frame_end = i[0]; i_x = 10'(i * 37); i_pause = 1'b0;
      @(negedge i_clk);
      chk("hold_rgb_a", rgb_a, 12'hFFF);
      chk("hold_sel_a", sel_a, 1);
      chk("hold_rgb_b", rgb_b, SQ_B);
      chk("hold_sel_b", sel_b, 2);
    end
    i_frame_end = 1'b0;

    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      i_pix_stb   = ($urandom_range(0, 2) == 0);
      i_x         = 10'(rnd_x());
      i_y         = 9'(rnd_y());
      i_active    = ($urandom_range(0, 7) == 0) ? 1'($urandom_range(0, 1))
                                                : (i_x < 640 && i_y < 480);
      i_hs        = 1'($urandom_range(0, 1));
      i_vs        = 1'($urandom_range(0, 1));
      i_frame_end = ($urandom_range(0, 5) == 0);
      i_pause     = ($urandom_range(0, 3) == 0);
      i_rst       = ($urandom_range(0, 299) == 0);
      @(negedge i_clk);
    end
    i_pix_stb = 1'b0; i_rst = 1'b0; i_frame_end = 1'b0;
    repeat (2) @(negedge i_clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
